// File: rtl/bka17_share_arbiter.sv
// Round-robin share arbiter feeding one 17-bit Brent-Kung adder through a two-stage
// pipeline (operand stage A, result stage B) with valid/ready on both sides.

module ubbka_16_0_16_0 (
  input  logic [16:0] a_i,
  input  logic [16:0] b_i,
  output logic [17:0] s_o
);
  localparam int W   = 17;
  localparam int LVL = 5;

  logic [W-1:0] p_s;
  logic [W-1:0] gp_s;
  logic [W-1:0] pp_s;

  // Brent-Kung prefix: up-sweep builds power-of-two spans, down-sweep fills the gaps
  always_comb begin
    int step;
    int j;
    step = 32'sd0;
    j    = 32'sd0;
    p_s  = a_i ^ b_i;
    gp_s = a_i & b_i;
    pp_s = p_s;
    for (int d = 0; d < LVL; d++) begin
      step = 32'sd1 << d;
      for (int i = 0; i < W; i++) begin
        j = (i >= step) ? (i - step) : 32'sd0;
        if (((i + 32'sd1) % (step * 32'sd2)) == 32'sd0) begin
          gp_s[i] = gp_s[i] | (pp_s[i] & gp_s[j]);
          pp_s[i] = pp_s[i] & pp_s[j];
        end else begin
          gp_s[i] = gp_s[i];
        end
      end
    end
    for (int d = LVL - 2; d >= 0; d--) begin
      step = 32'sd1 << d;
      for (int i = 0; i < W; i++) begin
        j = (i >= step) ? (i - step) : 32'sd0;
        if ((i >= (32'sd3 * step - 32'sd1)) &&
            (((i + 32'sd1 - step) % (step * 32'sd2)) == 32'sd0)) begin
          gp_s[i] = gp_s[i] | (pp_s[i] & gp_s[j]);
          pp_s[i] = pp_s[i] & pp_s[j];
        end else begin
          gp_s[i] = gp_s[i];
        end
      end
    end
  end

  // gp_s[i] is the carry out of bit i; carry-in is zero
  assign s_o = {gp_s[W-1], p_s ^ {gp_s[W-2:0], 1'b0}};
endmodule

module bka17_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NREQ-1:0]     req_valid_i,
  output logic [NREQ-1:0]     req_ready_o,
  input  logic [17*NREQ-1:0]  req_x_i,
  input  logic [17*NREQ-1:0]  req_y_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [17:0]         res_sum_o,
  output logic [IDW-1:0]      res_id_o,
  output logic [15:0]         acc_cnt_o
);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  logic [16:0]    opa_x_q, opa_x_d;
  logic [16:0]    opa_y_q, opa_y_d;
  logic [IDW-1:0] opa_id_q, opa_id_d;
  logic           a_full_q, a_full_d;
  logic [17:0]    res_sum_q, res_sum_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic           res_valid_q, res_valid_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [15:0]    acc_cnt_q, acc_cnt_d;

  logic [NREQ-1:0] grant_s;
  logic [IDW-1:0]  grant_id_s;
  logic            grant_found_s;
  logic            b_take_s;
  logic            a_free_s;
  logic            accept_s;
  logic [16:0]     sel_x_s;
  logic [16:0]     sel_y_s;
  logic [17:0]     add_sum_s;

  // Rotating priority search starting at ptr_q
  always_comb begin
    int idx;
    idx           = 32'sd0;
    grant_found_s = 1'b0;
    grant_id_s    = '0;
    grant_s       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (!grant_found_s && req_valid_i[idx]) begin
        grant_found_s = 1'b1;
        grant_id_s    = IDW'(idx);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
    grant_s[grant_id_s] = grant_found_s;
  end

  assign b_take_s    = a_full_q & (~res_valid_q | res_ready_i);
  assign a_free_s    = ~a_full_q | b_take_s;
  assign req_ready_o = grant_s & {NREQ{a_free_s & ~rst_i}};
  assign accept_s    = grant_found_s & a_free_s & ~rst_i;
  assign sel_x_s     = req_x_i[32'sd17 * int'(grant_id_s) +: 17];
  assign sel_y_s     = req_y_i[32'sd17 * int'(grant_id_s) +: 17];

  ubbka_16_0_16_0 u_adder (
    .a_i (opa_x_q),
    .b_i (opa_y_q),
    .s_o (add_sum_s)
  );

  // Next state of both stages, pointer and counter; accept and A->B move may share an edge
  always_comb begin
    opa_x_d     = opa_x_q;
    opa_y_d     = opa_y_q;
    opa_id_d    = opa_id_q;
    a_full_d    = a_full_q;
    res_sum_d   = res_sum_q;
    res_id_d    = res_id_q;
    res_valid_d = res_valid_q;
    ptr_d       = ptr_q;
    acc_cnt_d   = acc_cnt_q;

    if (accept_s) begin
      opa_x_d  = sel_x_s;
      opa_y_d  = sel_y_s;
      opa_id_d = grant_id_s;
      a_full_d = 1'b1;
      ptr_d    = (grant_id_s == LAST_ID) ? '0 : (grant_id_s + IDW'(1'b1));
      acc_cnt_d = acc_cnt_q + 16'd1;
    end else if (b_take_s) begin
      a_full_d = 1'b0;
    end else begin
      a_full_d = a_full_q;
    end

    if (b_take_s) begin
      res_sum_d   = add_sum_s;
      res_id_d    = opa_id_q;
      res_valid_d = 1'b1;
    end else if (res_valid_q && res_ready_i) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      opa_x_q     <= 17'd0;
      opa_y_q     <= 17'd0;
      opa_id_q    <= '0;
      a_full_q    <= 1'b0;
      res_sum_q   <= 18'd0;
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
      ptr_q       <= '0;
      acc_cnt_q   <= 16'd0;
    end else begin
      opa_x_q     <= opa_x_d;
      opa_y_q     <= opa_y_d;
      opa_id_q    <= opa_id_d;
      a_full_q    <= a_full_d;
      res_sum_q   <= res_sum_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
      ptr_q       <= ptr_d;
      acc_cnt_q   <= acc_cnt_d;
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_sum_o   = res_sum_q;
  assign res_id_o    = res_id_q;
  assign acc_cnt_o   = acc_cnt_q;
endmodule
